pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/stall/flush controller for the 5-stage pipelined CPU.
//  Generates PC and IF/ID enables, per-register flushes and EX forwarding selects.
//  Tracks per-stage valid bits and sequences instruction-cache miss stalls with a timeout.
//  Sits beside the pipe registers; the cpu top wires its outputs into them.
// PARAMETERS
//  REG_ADDR_W       5    register-index width
//  MISS_MAX_CYCLES  16   consecutive miss cycles before miss_timeout is raised (>=1)
//  CNT_W            32   performance-counter width (used only with PIPE_PERF_CNT_EN)
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           asynchronous, active-high
//  if_hit         in   1           fetch cache hit this cycle
//  id_rs,id_rt    in   REG_ADDR_W  decode source registers
//  id_uses_rt     in   1           decode instruction reads rt
//  ex_rs,ex_rt    in   REG_ADDR_W  EX-stage source registers
//  ex_rd          in   REG_ADDR_W  EX destination; ex_reg_write, ex_mem_read in 1 each
//  mem_rd         in   REG_ADDR_W  MEM destination; mem_reg_write in 1
//  wb_rd          in   REG_ADDR_W  WB destination; wb_reg_write in 1
//  mem_pcsrc      in   1           taken branch resolved in MEM
//  pc_en          out  1           PC load enable
//  if_id_en       out  1           IF/ID register enable
//  if_id_flush, id_ex_flush, ex_mem_flush  out 1 each  insert bubble
//  fwd_a,fwd_b    out  2           00 regfile, 01 from WB, 10 from MEM
//  stage_valid    out  4           [0]IF/ID [1]ID/EX [2]EX/MEM [3]MEM/WB
//  miss_timeout   out  1           sticky error flag
// BEHAVIOUR
//  States: RUN, MISS (registered). Reset: RUN, stage_valid=0, miss_timeout=0, miss counter=0.
//  While reset is high: pc_en=0, if_id_en=0, all flushes=1, fwd_a=fwd_b=00.
//  Priority, highest first: branch > miss > load-use.
//  Branch (mem_pcsrc=1, any state): pc_en=1; all three flushes=1; next state RUN; miss counter cleared.
//  RUN & if_hit=0: go to MISS. Same cycle: pc_en=0, if_id_flush=1.
//  MISS: pc_en=0, if_id_flush=1; downstream advances; counter increments per cycle.
//  MISS & if_hit=1: go to RUN and clear counter. pc_en=1, if_id_en=1 that cycle.
//  Counter reaches MISS_MAX_CYCLES: miss_timeout=1 next cycle; sticky until reset; FSM unaffected.
//  Load-use in RUN with hit: ex_mem_read & stage_valid[1] & ex_rd!=0 and
//  (ex_rd==id_rs | id_uses_rt & ex_rd==id_rt). Response: pc_en=0, if_id_en=0,
//  id_ex_flush=1 for exactly one cycle; it clears once the load leaves EX.
//  No hazard: pc_en=1, if_id_en=1, flushes=0.
//  Valid bits: flushed stage loads 0; IF/ID loads if_hit when enabled, else holds;
//  other stages shift from the previous bit every cycle.
//  Forwarding (combinational):
//    fwd_a=10 if mem_reg_write & stage_valid[2] & mem_rd!=0 & mem_rd==ex_rs;
//    else 01 if wb_reg_write & stage_valid[3] & wb_rd!=0 & wb_rd==ex_rs; else 00.
//    fwd_b is identical using ex_rt. MEM beats WB; register 0 is never forwarded.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs cyc_cnt, stall_cnt, flush_cnt [CNT_W-1:0].
//    Counters reset to 0 and wrap modulo 2^CNT_W.
//    stall_cnt counts cycles with pc_en=0 outside reset; flush_cnt counts taken branches.
//  Undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package pipe_ctrl_pkg: fwd_sel_t (FWD_RF=00, FWD_WB=01, FWD_MEM=10),
//    state_t (RUN, MISS), stage index constants SV_IFID..SV_MEMWB.
//  Sub-module pipe_fwd_sel: one operand's forward select. Instantiated twice (rs, rt).
// TESTING
//  Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, stage_valid[1]=1 -> one cycle of
//    pc_en=0, if_id_en=0, id_ex_flush=1; then pc_en=1.
//  Forward priority: mem_rd=wb_rd=ex_rs=3, both writes and valids set -> fwd_a=10.
//    With mem_rd=wb_rd=0 -> 00.
//  Miss/branch: if_hit=0 for 2 cycles, then mem_pcsrc=1 -> RUN, all flushes=1,
//    pc_en=1, stage_valid[2:0]=0 next cycle.
//  Timeout: MISS_MAX_CYCLES=4, if_hit held 0 -> miss_timeout=1 after 4 MISS cycles;
//    stays 1 after if_hit returns.
//  Reset mid-MISS: assert reset asynchronously -> stage_valid=0, miss_timeout=0,
//    flushes=1 immediately.
//  PIPE_PERF_CNT_EN: 3 stall cycles + 1 branch over 10 cycles -> stall_cnt=3,
//    flush_cnt=1, cyc_cnt=10.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } state_t;

  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned SV_IFID    = 0;
  localparam int unsigned SV_IDEX    = 1;
  localparam int unsigned SV_EXMEM   = 2;
  localparam int unsigned SV_MEMWB   = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bus between the CPU datapath (master) and the hazard controller (slave).
// PIPE_PERF_CNT_EN adds the cyc_cnt/stall_cnt/flush_cnt performance counters.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
  #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
  );

  logic                  if_hit;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;
  logic                  mem_pcsrc;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  fwd_sel_t              fwd_a;
  fwd_sel_t              fwd_b;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  miss_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]      cyc_cnt;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output if_hit, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_pcsrc,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
           stage_valid, miss_timeout, cyc_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_hit, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_pcsrc,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
           stage_valid, miss_timeout, cyc_cnt, stall_cnt, flush_cnt
  );
`else
  localparam int unsigned unused_cnt_w = CNT_W;

  modport master (
    output if_hit, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_pcsrc,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
           stage_valid, miss_timeout
  );

  modport slave (
    input  if_hit, id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_pcsrc,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
           stage_valid, miss_timeout
  );
`endif

endinterface

// File: rtl/pipe_fwd_sel.sv
// EX-operand forward select for one source register; MEM result beats WB, r0 never forwarded.
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
  #(
    parameter int unsigned REG_ADDR_W = 5
  ) (
    input  logic [REG_ADDR_W-1:0] ex_src,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  wb_valid,
    output fwd_sel_t              sel
  );

  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && mem_valid && (mem_rd != '0) && (mem_rd == ex_src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && wb_valid && (wb_rd != '0) && (wb_rd == ex_src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush controller for the 5-stage pipeline: branch flush, I-cache miss
// sequencing with sticky timeout, load-use stall, stage valids and EX forwarding.
// PIPE_PERF_CNT_EN adds cycle/stall/branch-flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
  #(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned MISS_MAX_CYCLES = 16,
    parameter int unsigned CNT_W           = 32
  ) (
    input logic                clk,
    input logic                reset,
    pipe_hazard_ctrl_if.slave  bus
  );

  localparam int unsigned MISS_CNT_W = $clog2(MISS_MAX_CYCLES + 1);

  state_t                  state_q, state_d;
  logic [MISS_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                    timeout_q;
  logic                    set_timeout;
  logic [NUM_STAGES-1:0]   valid_q;
  logic                    load_use;
  logic                    pc_en_d, if_id_en_d;
  logic                    if_id_flush_d, id_ex_flush_d, ex_mem_flush_d;
  fwd_sel_t                sel_a, sel_b;
  logic                    unused_ex_reg_write;

  assign unused_ex_reg_write = bus.ex_reg_write;

  // A load in EX whose destination feeds the instruction now in decode.
  assign load_use = bus.ex_mem_read && valid_q[SV_IDEX] && (bus.ex_rd != '0) &&
                    ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    miss_cnt_d     = miss_cnt_q;
    set_timeout    = 1'b0;
    pc_en_d        = 1'b1;
    if_id_en_d     = 1'b1;
    if_id_flush_d  = 1'b0;
    id_ex_flush_d  = 1'b0;
    ex_mem_flush_d = 1'b0;
    if (bus.mem_pcsrc) begin
      if_id_flush_d  = 1'b1;
      id_ex_flush_d  = 1'b1;
      ex_mem_flush_d = 1'b1;
      state_d        = RUN;
      miss_cnt_d     = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.if_hit) begin
            state_d       = MISS;
            pc_en_d       = 1'b0;
            if_id_flush_d = 1'b1;
          end else if (load_use) begin
            pc_en_d       = 1'b0;
            if_id_en_d    = 1'b0;
            id_ex_flush_d = 1'b1;
          end
        end
        MISS: begin
          if (bus.if_hit) begin
            state_d    = RUN;
            miss_cnt_d = '0;
          end else begin
            pc_en_d       = 1'b0;
            if_id_flush_d = 1'b1;
            // Counter saturates at the limit; the timeout is raised as it gets there.
            if (miss_cnt_q != MISS_CNT_W'(MISS_MAX_CYCLES)) begin
              miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
            end
            if (miss_cnt_q == MISS_CNT_W'(MISS_MAX_CYCLES - 1)) begin
              set_timeout = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt_q <= '0;
      timeout_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      if (set_timeout) timeout_q <= 1'b1;
      valid_q[SV_IFID]  <= if_id_flush_d  ? 1'b0 :
                           (if_id_en_d ? bus.if_hit : valid_q[SV_IFID]);
      valid_q[SV_IDEX]  <= id_ex_flush_d  ? 1'b0 : valid_q[SV_IFID];
      valid_q[SV_EXMEM] <= ex_mem_flush_d ? 1'b0 : valid_q[SV_IDEX];
      valid_q[SV_MEMWB] <= valid_q[SV_EXMEM];
    end
  end

  pipe_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_src        (bus.ex_rs),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .mem_valid     (valid_q[SV_EXMEM]),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_valid      (valid_q[SV_MEMWB]),
    .sel           (sel_a)
  );

  pipe_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_src        (bus.ex_rt),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .mem_valid     (valid_q[SV_EXMEM]),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_valid      (valid_q[SV_MEMWB]),
    .sel           (sel_b)
  );

  // Reset holds the pipe frozen with bubbles in every register.
  always_comb begin
    bus.pc_en        = reset ? 1'b0   : pc_en_d;
    bus.if_id_en     = reset ? 1'b0   : if_id_en_d;
    bus.if_id_flush  = reset ? 1'b1   : if_id_flush_d;
    bus.id_ex_flush  = reset ? 1'b1   : id_ex_flush_d;
    bus.ex_mem_flush = reset ? 1'b1   : ex_mem_flush_d;
    bus.fwd_a        = reset ? FWD_RF : sel_a;
    bus.fwd_b        = reset ? FWD_RF : sel_b;
  end

  assign bus.stage_valid  = valid_q;
  assign bus.miss_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (!pc_en_d)      stall_q <= stall_q + CNT_W'(1);
      if (bus.mem_pcsrc) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.cyc_cnt   = cyc_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
